// File: rtl/dual_port_ram_pkg.sv
// Shared types and helpers for the byte-enabled true dual-port RAM.
package dual_port_ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int RDW_OLD_DATA = 0;
  localparam int RDW_NEW_DATA = 1;

  function automatic int num_bytes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/dual_port_ram_read_pipe.sv
// Per-port read data/valid delay line; 1 or 2 register stages, flushed by rst.
module dual_port_ram_read_pipe #(
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o
);

  logic                  vld_p0_q;
  logic [DATA_WIDTH-1:0] data_p0_q;

  // Stage p0: capture the word addressed by the request
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q  <= 1'b0;
      data_p0_q <= '0;
    end else begin
      vld_p0_q <= rd_req_i;
      if (rd_req_i) begin
        data_p0_q <= rd_data_i;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  vld_p1_q;
    logic [DATA_WIDTH-1:0] data_p1_q;

    // Stage p1: output register, loads only on valid so data holds otherwise
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p1_q  <= 1'b0;
        data_p1_q <= '0;
      end else begin
        vld_p1_q <= vld_p0_q;
        if (vld_p0_q) begin
          data_p1_q <= data_p0_q;
        end
      end
    end

    assign data_o  = data_p1_q;
    assign valid_o = vld_p1_q;
  end else begin : g_lat1
    assign data_o  = data_p0_q;
    assign valid_o = vld_p0_q;
  end

endmodule

// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with byte enables, init-after-reset engine, selectable
// read latency and cross-port read-during-write behaviour.
module dual_port_ram_be
  import dual_port_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    BYTE_WIDTH   = 8,
  parameter int                    ADDR_WIDTH   = 6,
  parameter int                    READ_LATENCY = 1,
  parameter int                    RDW_MODE     = RDW_OLD_DATA,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             ready,
  output logic                             collision,
  input  logic                             port1_en,
  input  logic                             port1_write_en,
  input  logic [ADDR_WIDTH-1:0]            port1_addr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] port1_byte_en,
  input  logic [DATA_WIDTH-1:0]            port1_data_in,
  output logic [DATA_WIDTH-1:0]            port1_data_out,
  output logic                             port1_data_valid,
  input  logic                             port2_en,
  input  logic                             port2_write_en,
  input  logic [ADDR_WIDTH-1:0]            port2_addr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] port2_byte_en,
  input  logic [DATA_WIDTH-1:0]            port2_data_in,
  output logic [DATA_WIDTH-1:0]            port2_data_out,
  output logic                             port2_data_valid
);

  localparam int NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_byte_width
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] base,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [NUM_BYTES-1:0]  be
  );
    logic [DATA_WIDTH-1:0] res;
    res = base;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (be[b]) begin
        res[b*BYTE_WIDTH +: BYTE_WIDTH] = wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    return res;
  endfunction

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  collision_q;

  logic                  accept;
  logic                  init_wr;
  logic                  wr1, wr2, rd1, rd2;
  logic                  same_addr;
  logic [DATA_WIDTH-1:0] rd1_word, rd2_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Requests seen on a reset edge are dropped along with everything in flight
  assign ready     = (state_q == ST_RUN);
  assign accept    = ready && !rst;
  assign init_wr   = (state_q == ST_INIT) && !rst;
  assign wr1       = accept && port1_en && port1_write_en;
  assign wr2       = accept && port2_en && port2_write_en;
  assign rd1       = accept && port1_en && !port1_write_en;
  assign rd2       = accept && port2_en && !port2_write_en;
  assign same_addr = (port1_addr == port2_addr);

  // Port 1 lanes are assigned last so they win on a same-address dual write
  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem_q[init_cnt_q] <= INIT_VALUE;
    end else begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wr2 && port2_byte_en[b]) begin
          mem_q[port2_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <=
            port2_data_in[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
        if (wr1 && port1_byte_en[b]) begin
          mem_q[port1_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <=
            port1_data_in[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_comb begin
    rd1_word = mem_q[port1_addr];
    rd2_word = mem_q[port2_addr];
    if (RDW_MODE == RDW_NEW_DATA) begin
      if (wr2 && same_addr) begin
        rd1_word = merge_lanes(mem_q[port1_addr], port2_data_in, port2_byte_en);
      end
      if (wr1 && same_addr) begin
        rd2_word = merge_lanes(mem_q[port2_addr], port1_data_in, port1_byte_en);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= wr1 && wr2 && same_addr;
    end
  end

  assign collision = collision_q;

  dual_port_ram_read_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe1 (
    .clk      (clk),
    .rst      (rst),
    .rd_req_i (rd1),
    .rd_data_i(rd1_word),
    .data_o   (port1_data_out),
    .valid_o  (port1_data_valid)
  );

  dual_port_ram_read_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe2 (
    .clk      (clk),
    .rst      (rst),
    .rd_req_i (rd2),
    .rd_data_i(rd2_word),
    .data_o   (port2_data_out),
    .valid_o  (port2_data_valid)
  );

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: instance A (latency 1, old data), instance B
// (latency 2, new data) share stimulus and are checked against one array model.
module tb_dual_port_ram_be;

  localparam logic [15:0] INIT = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        p1_en, p1_we, p2_en, p2_we;
  logic [5:0]  p1_addr, p2_addr;
  logic [1:0]  p1_be, p2_be;
  logic [15:0] p1_din, p2_din;

  logic        rdyA, colA, p1vA, p2vA, rdyB, colB, p1vB, p2vB;
  logic [15:0] p1doA, p2doA, p1doB, p2doB;

  always #5 clk = ~clk;

  dual_port_ram_be #(
    .DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(6),
    .READ_LATENCY(1), .RDW_MODE(0), .INIT_VALUE(INIT)
  ) dut_a (
    .clk(clk), .rst(rst), .ready(rdyA), .collision(colA),
    .port1_en(p1_en), .port1_write_en(p1_we), .port1_addr(p1_addr),
    .port1_byte_en(p1_be), .port1_data_in(p1_din),
    .port1_data_out(p1doA), .port1_data_valid(p1vA),
    .port2_en(p2_en), .port2_write_en(p2_we), .port2_addr(p2_addr),
    .port2_byte_en(p2_be), .port2_data_in(p2_din),
    .port2_data_out(p2doA), .port2_data_valid(p2vA)
  );

  dual_port_ram_be #(
    .DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(6),
    .READ_LATENCY(2), .RDW_MODE(1), .INIT_VALUE(INIT)
  ) dut_b (
    .clk(clk), .rst(rst), .ready(rdyB), .collision(colB),
    .port1_en(p1_en), .port1_write_en(p1_we), .port1_addr(p1_addr),
    .port1_byte_en(p1_be), .port1_data_in(p1_din),
    .port1_data_out(p1doB), .port1_data_valid(p1vB),
    .port2_en(p2_en), .port2_write_en(p2_we), .port2_addr(p2_addr),
    .port2_byte_en(p2_be), .port2_data_in(p2_din),
    .port2_data_out(p2doB), .port2_data_valid(p2vB)
  );

  // Reference model state
  logic [15:0] mdl [64];
  int          init_cnt = 0;
  bit          rdy_m = 1'b0;
  logic [15:0] hA1 = '0, hA2 = '0, hB1 = '0, hB2 = '0;
  bit          bq1_v = 1'b0, bq2_v = 1'b0;
  logic [15:0] bq1_d = '0, bq2_d = '0;
  int          n_cmp = 0, n_err = 0;
  string       phase = "reset";
  int          cntA1, cntA2, cntB1, cntB2;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s: observed %h expected %h", phase, tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s: observed %b expected %b", phase, tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] overlay(input logic [15:0] base, input logic [15:0] wd,
                                          input logic [1:0] be);
    return {be[1] ? wd[15:8] : base[15:8], be[0] ? wd[7:0] : base[7:0]};
  endfunction

  task automatic idle();
    p1_en = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_be = '0; p1_din = '0;
    p2_en = 1'b0; p2_we = 1'b0; p2_addr = '0; p2_be = '0; p2_din = '0;
  endtask

  task automatic drive1(input logic we, input int addr, input logic [1:0] be, input logic [15:0] d);
    p1_en = 1'b1; p1_we = we; p1_addr = 6'(addr); p1_be = be; p1_din = d;
  endtask

  task automatic drive2(input logic we, input int addr, input logic [1:0] be, input logic [15:0] d);
    p2_en = 1'b1; p2_we = we; p2_addr = 6'(addr); p2_be = be; p2_din = d;
  endtask

  task automatic randomize_inputs(input int amax);
    p1_en = 1'($urandom); p1_we = 1'($urandom); p1_addr = 6'($urandom_range(0, amax));
    p1_be = 2'($urandom); p1_din = 16'($urandom);
    p2_en = 1'($urandom); p2_we = 1'($urandom); p2_addr = 6'($urandom_range(0, amax));
    p2_be = 2'($urandom); p2_din = 16'($urandom);
  endtask

  // One clock: predict from the pre-edge model, advance, then compare outputs.
  task automatic step();
    bit          acc, r1, r2, w1, w2, same, cexp, vB1, vB2;
    logic [15:0] o1, o2, n1, n2;
    acc  = !rst && rdy_m;
    r1   = acc && p1_en && !p1_we;
    r2   = acc && p2_en && !p2_we;
    w1   = acc && p1_en && p1_we;
    w2   = acc && p2_en && p2_we;
    same = (p1_addr == p2_addr);
    o1   = mdl[p1_addr];
    o2   = mdl[p2_addr];
    n1   = (w2 && same) ? overlay(o1, p2_din, p2_be) : o1;
    n2   = (w1 && same) ? overlay(o2, p1_din, p1_be) : o2;
    cexp = w1 && w2 && same;

    if (rst) begin
      init_cnt = 0;
      rdy_m    = 1'b0;
    end else if (!rdy_m) begin
      mdl[init_cnt] = INIT;
      init_cnt++;
      rdy_m = (init_cnt == 64);
    end else if (w1 && w2 && same) begin
      mdl[p1_addr] = {p1_be[1] ? p1_din[15:8] : (p2_be[1] ? p2_din[15:8] : o1[15:8]),
                      p1_be[0] ? p1_din[7:0]  : (p2_be[0] ? p2_din[7:0]  : o1[7:0])};
    end else begin
      if (w1) mdl[p1_addr] = overlay(o1, p1_din, p1_be);
      if (w2) mdl[p2_addr] = overlay(o2, p2_din, p2_be);
    end

    @(posedge clk);
    #1;

    if (rst) begin
      hA1 = '0; hA2 = '0; hB1 = '0; hB2 = '0;
      bq1_v = 1'b0; bq2_v = 1'b0;
      vB1 = 1'b0; vB2 = 1'b0;
    end else begin
      if (r1) hA1 = o1;
      if (r2) hA2 = o2;
      vB1 = bq1_v;
      vB2 = bq2_v;
      if (vB1) hB1 = bq1_d;
      if (vB2) hB2 = bq2_d;
      bq1_v = r1; bq1_d = n1;
      bq2_v = r2; bq2_d = n2;
    end

    chk1("A_ready", rdyA, rdy_m);
    chk1("B_ready", rdyB, rdy_m);
    chk1("A_collision", colA, cexp && !rst);
    chk1("B_collision", colB, cexp && !rst);
    chk1("A_p1_valid", p1vA, r1);
    chk1("A_p2_valid", p2vA, r2);
    chk1("B_p1_valid", p1vB, vB1);
    chk1("B_p2_valid", p2vB, vB2);
    chk16("A_p1_data", p1doA, hA1);
    chk16("A_p2_data", p2doA, hA2);
    chk16("B_p1_data", p1doB, hB1);
    chk16("B_p2_data", p2doB, hB2);
    if (p1vA) cntA1++;
    if (p2vA) cntA2++;
    if (p1vB) cntB1++;
    if (p2vB) cntB2++;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    step();

    phase = "init";
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      randomize_inputs(63);
      step();
    end
    chk1("ready_after_64", rdyA, 1'b1);

    phase = "init_read";
    idle(); drive1(1'b0, 0, 2'b00, '0); drive2(1'b0, 31, 2'b00, '0);
    step();
    chk16("addr0", p1doA, INIT);
    chk16("addr31", p2doA, INIT);
    idle(); drive1(1'b0, 63, 2'b00, '0);
    step();
    chk16("addr63", p1doA, INIT);
    idle(); step(); step();

    phase = "byte_en";
    drive1(1'b1, 5, 2'b11, 16'h1234); step();
    idle(); drive1(1'b1, 5, 2'b01, 16'hFFAB); step();
    idle(); drive2(1'b0, 5, 2'b00, '0); step();
    chk1("lat1_valid", p2vA, 1'b1);
    chk16("lat1_data", p2doA, 16'h12AB);
    idle(); step();
    chk1("lat2_valid", p2vB, 1'b1);
    chk16("lat2_data", p2doB, 16'h12AB);

    phase = "rdw";
    drive1(1'b1, 9, 2'b11, 16'h0000); step();
    idle(); drive1(1'b0, 9, 2'b00, '0); drive2(1'b1, 9, 2'b11, 16'hBEEF); step();
    chk16("old_data", p1doA, 16'h0000);
    idle(); step();
    chk16("new_data", p1doB, 16'hBEEF);
    drive1(1'b0, 9, 2'b00, '0); step();
    chk16("reread_A", p1doA, 16'hBEEF);
    idle(); step();
    chk16("reread_B", p1doB, 16'hBEEF);

    phase = "collision";
    drive1(1'b1, 3, 2'b10, 16'h1111); drive2(1'b1, 3, 2'b11, 16'h2222); step();
    chk1("coll_pulse", colA, 1'b1);
    idle(); step();
    chk1("coll_end", colA, 1'b0);
    drive1(1'b0, 3, 2'b00, '0); step();
    chk16("merged", p1doA, 16'h1122);
    idle(); step();

    phase = "stream";
    cntA1 = 0; cntA2 = 0; cntB1 = 0; cntB2 = 0;
    for (int i = 0; i < 64; i++) begin
      drive1(1'b0, i, 2'b00, '0);
      drive2(1'b0, 63 - i, 2'b00, '0);
      step();
    end
    idle(); step(); step();
    chk16("A_p1_pulses", 16'(cntA1), 16'd64);
    chk16("A_p2_pulses", 16'(cntA2), 16'd64);
    chk16("B_p1_pulses", 16'(cntB1), 16'd64);
    chk16("B_p2_pulses", 16'(cntB2), 16'd64);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      randomize_inputs((i < 200) ? 7 : 63);
      step();
    end
    idle(); step(); step();

    phase = "mid_reset";
    drive1(1'b0, 10, 2'b00, '0); drive2(1'b0, 20, 2'b00, '0); step();
    rst = 1'b1; step();
    rst = 1'b0; idle(); step();
    chk1("ready_low", rdyA, 1'b0);
    for (int i = 0; i < 63; i++) begin
      randomize_inputs(63);
      step();
    end
    idle(); step();
    drive1(1'b0, 5, 2'b00, '0); drive2(1'b0, 3, 2'b00, '0); step();
    chk16("reinit_addr5", p1doA, INIT);
    chk16("reinit_addr3", p2doA, INIT);
    idle(); step();
    chk16("reinit_B_addr3", p2doB, INIT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_be.md
Name: dual_port_ram_be

Overview:
Parametrised true dual-port RAM: two independent read/write ports on a single clock, with per-byte write enables, selectable read latency and selectable cross-port read-during-write behaviour. A built-in init engine clears the array after every reset. Same-address write collisions are arbitrated and flagged. It is the general-purpose storage macro for register files and small buffers, replacing fixed-width, fixed-depth memories.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of BYTE_WIDTH (elaboration error otherwise)
BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH
ADDR_WIDTH, 6, address width; DEPTH = 2**ADDR_WIDTH
READ_LATENCY, 1, 1 or 2 cycles from read request to data_valid; other values are an elaboration error
RDW_MODE, 0, cross-port read of a word written the same cycle: 0 = old data, 1 = new (merged) data
INIT_VALUE, 0, DATA_WIDTH-bit value written to every word during init

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
ready  out  1  high when init is complete and requests are accepted
collision  out  1  one-cycle pulse: both ports wrote the same address
port1_en  in  1  port 1 access request
port1_write_en  in  1  1 = write, 0 = read (qualified by port1_en)
port1_addr  in  ADDR_WIDTH  port 1 address
port1_byte_en  in  NUM_BYTES  port 1 write lane enables
port1_data_in  in  DATA_WIDTH  port 1 write data
port1_data_out  out  DATA_WIDTH  port 1 read data
port1_data_valid  out  1  port 1 read data valid, one pulse per read
port2_*  identical set for port 2

Behaviour:
- Reset, sampled on the clock edge: state=ST_INIT, init counter=0, ready=0, collision=0, both data_out=0, both data_valid=0, read pipelines flushed.
- ST_INIT: each cycle, write INIT_VALUE to address = counter, then counter+1. The first cycle with rst low writes address 0.
- After address DEPTH-1 is written, go to ST_RUN. ready rises exactly DEPTH cycles after the first cycle with rst low.
- All port requests are ignored in ST_INIT: no writes, no data_valid.
- ST_RUN is the terminal state; only rst leaves it. rst asserted mid-operation drops in-flight reads (no valid pulse) and reruns the full init.
- Write: en=1, write_en=1. Lane i is updated iff byte_en[i]. Lanes with byte_en=0 keep their stored value. Writes produce no data_valid.
- Read: en=1, write_en=0.
  - READ_LATENCY=1: data_out/data_valid at edge N+1 for a request at edge N.
  - READ_LATENCY=2: an additional output register is added, giving edge N+2.
  - Back-to-back reads every cycle are supported; there are no bubbles.
- data_out holds its last read value while data_valid=0.
- Cross-port read-during-write, same address, same cycle:
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the word with the other port's enabled lanes merged in.
- Dual write, same address, same cycle:
  - Each lane takes port 1's data if port1_byte_en[i], else port 2's data if port2_byte_en[i], else keeps its stored value.
  - collision pulses one cycle later (registered), regardless of whether the byte enables overlap.
- Dual write to different addresses: both complete, no collision.

Decomposition:
- Package dual_port_ram_pkg: state enum (ST_INIT, ST_RUN), RDW_OLD_DATA=0 / RDW_NEW_DATA=1 constants, and a function computing NUM_BYTES.
- One sub-module, dual_port_ram_read_pipe: a per-port data/valid delay line parametrised by READ_LATENCY and DATA_WIDTH, with synchronous flush on rst. It is instantiated twice.
- The array, write arbitration, init FSM and collision register live in the top module.

Test Plan:
- Release rst, ADDR_WIDTH=6, INIT_VALUE=16'hA5A5 -> ready=0 for 64 cycles then 1; reads of addrs 0, 31 and 63 return 16'hA5A5; requests issued during init have no effect.
- Port 1 writes addr 5 = 16'h1234 with byte_en=2'b11, then byte_en=2'b01 with 16'hFFAB -> port 2 read of addr 5 returns 16'h12AB, valid exactly READ_LATENCY cycles after the request (run with READ_LATENCY=1 and =2).
- Addr 9 holds 16'h0000; port 1 reads addr 9 while port 2 writes 16'hBEEF there in the same cycle -> RDW_MODE=0 returns 16'h0000, RDW_MODE=1 returns 16'hBEEF; a subsequent read returns 16'hBEEF in both modes.
- Both ports write addr 3 in the same cycle: port1 16'h1111 with byte_en=2'b10, port2 16'h2222 with byte_en=2'b11 -> addr 3 = 16'h1122; collision pulses for exactly one cycle, on the following cycle.
- Both ports issue continuous reads of addresses 0..63 -> 64 consecutive valid pulses per port with correct data and no gaps.
- Reads in flight, then rst for 1 cycle -> no valid pulses from the dropped reads; ready low; memory re-initialised to INIT_VALUE.
